// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants for the 7-segment scanner: hex decode map,
//                blank pattern and scan state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] c_SEG_OFF = 7'h7F;

    localparam logic [0:0] c_ST_BLANK = 1'b0;
    localparam logic [0:0] c_ST_SHOW  = 1'b1;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational 4-bit hex to 7-segment (active-high) decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = c_HEX_SEG[hex];
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scanner
//  Description : Time-multiplexed common-anode 7-segment driver with dwell,
//                inter-digit blanking and once-per-frame data snapshot.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1024,
    parameter int BLANK  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     en,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  frame_tick
);

    localparam int c_CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(DIGITS - 1);

    logic [0:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [4*DIGITS-1:0]    r_data_sh;
    logic [DIGITS-1:0]      r_dp_sh;
    logic [DIGITS-1:0]      r_en_sh;
    logic [DIGITS-1:0]      r_an_n;
    logic [6:0]             r_seg_n;
    logic                   r_dp_n;
    logic                   r_frame_tick;

    logic [0:0]             w_state_nxt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [c_IDX_W-1:0]     w_idx_nxt;
    logic                   w_snap;
    logic                   w_tick_nxt;
    logic [4*DIGITS-1:0]    w_data_sh_nxt;
    logic [DIGITS-1:0]      w_dp_sh_nxt;
    logic [DIGITS-1:0]      w_en_sh_nxt;
    logic [3:0]             w_nibble;
    logic [6:0]             w_seg;
    logic [DIGITS-1:0]      w_an_n_nxt;
    logic [6:0]             w_seg_n_nxt;
    logic                   w_dp_n_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_snap      = 1'b0;
        w_tick_nxt  = 1'b0;
        case (r_state)
            c_ST_BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_state_nxt = c_ST_SHOW;
                    w_cnt_nxt   = '0;
                    w_snap      = (r_idx == '0);
                end
            end
            default: begin
                if (r_cnt == c_DWELL_LAST) begin
                    w_state_nxt = c_ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
                    w_tick_nxt  = (r_idx == c_IDX_LAST);
                end
            end
        endcase
    end

    // Outputs are computed from the next-cycle view (including a snapshot
    // captured on this same edge) so they change together with the state.
    assign w_data_sh_nxt = w_snap ? data : r_data_sh;
    assign w_dp_sh_nxt   = w_snap ? dp   : r_dp_sh;
    assign w_en_sh_nxt   = w_snap ? en   : r_en_sh;
    assign w_nibble      = w_data_sh_nxt[4*r_idx +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .hex (w_nibble),
        .seg (w_seg)
    );

    always_comb begin
        w_an_n_nxt  = '1;
        w_seg_n_nxt = c_SEG_OFF;
        w_dp_n_nxt  = 1'b1;
        if (w_state_nxt == c_ST_SHOW && w_en_sh_nxt[r_idx]) begin
            w_an_n_nxt[r_idx] = 1'b0;
            w_seg_n_nxt       = ~w_seg;
            w_dp_n_nxt        = ~w_dp_sh_nxt[r_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_data_sh    <= '0;
            r_dp_sh      <= '0;
            r_en_sh      <= '0;
            r_an_n       <= '1;
            r_seg_n      <= c_SEG_OFF;
            r_dp_n       <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_data_sh    <= w_data_sh_nxt;
            r_dp_sh      <= w_dp_sh_nxt;
            r_en_sh      <= w_en_sh_nxt;
            r_an_n       <= w_an_n_nxt;
            r_seg_n      <= w_seg_n_nxt;
            r_dp_n       <= w_dp_n_nxt;
            r_frame_tick <= w_tick_nxt;
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: doc/seg7_scanner.md
Name: seg7_scanner

Overview:
- Time-multiplexed driver for a common-anode multi-digit 7-segment display.
- Output-side counterpart to the button input conditioning: the CPU and register-view logic present hex values, and this block drives them to the board pins.
- Cycles through the digits with a dwell period and an inter-digit blanking gap to suppress ghosting.
- Snapshots display data once per frame so the display never shows a half-updated value.

Parameters:
- DIGITS, 4: number of digits scanned; must be ≥ 1.
- DWELL, 1024: clock cycles each digit is lit; must be ≥ 1.
- BLANK, 16: clock cycles with all digits off between two digits; must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- data  in  4*DIGITS  hex nibbles; digit i is data[4i+3:4i]; digit 0 is rightmost
- dp  in  DIGITS  decimal point request per digit, 1 = on
- en  in  DIGITS  digit enable, 1 = show, 0 = keep the digit dark
- an_n  out  DIGITS  anode selects, active-low
- seg_n  out  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- dp_n  out  1  decimal point drive, active-low
- frame_tick  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Clock and reset:
  - Single clock domain.
  - The design is "one clock; reset is asynchronous and active-high": clk, rst.
  - Every output is registered. No combinational path from inputs to outputs.
- Reset values:
  - an_n = all 1, seg_n = 7'h7F, dp_n = 1, frame_tick = 0.
  - state = BLANK, idx = 0, cnt = 0, shadow registers = 0.
- State machine, two states, with cnt counting inside each state:
  - BLANK: all outputs off (an_n all 1, seg_n 7'h7F, dp_n 1). cnt runs 0..BLANK-1. On the edge where cnt = BLANK-1: go to SHOW, clear cnt.
  - SHOW:
    - an_n[idx] = ~en_sh[idx]; all other anodes stay 1.
    - seg_n = ~decode(data_sh[idx]).
    - dp_n = ~dp_sh[idx].
    - If en_sh[idx] = 0, seg_n and dp_n are also forced to 1.
    - cnt runs 0..DWELL-1. On the edge where cnt = DWELL-1: go to BLANK, clear cnt, idx = (idx = DIGITS-1) ? 0 : idx+1.
- Outputs update on the same clock edge as the state and idx change.
- Frame snapshot:
  - On the BLANK→SHOW edge with idx = 0, data, dp and en are captured into data_sh, dp_sh and en_sh.
  - Input changes at any other time take effect only at the next frame.
- frame_tick:
  - High for exactly one cycle, the cycle after the SHOW→BLANK edge with idx = DIGITS-1.
  - Frame period = DIGITS*(DWELL+BLANK) cycles.
- First lit digit: digit 0 appears on the BLANK-th rising edge after rst deasserts.
- Decode map (gfedcba, active-high before inversion):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- No two anodes are ever low in the same cycle, including across state transitions.
- Reset asserted mid-scan: all outputs return to their off values immediately (asynchronously). Scanning restarts from digit 0 with a fresh snapshot.
- DIGITS = 1: idx stays at 0. Every frame re-snapshots, and frame_tick pulses every DWELL+BLANK cycles.
- Counter widths:
  - cnt is $clog2(max(DWELL,BLANK)+1) bits.
  - idx is max(1,$clog2(DIGITS)) bits.
  - Neither counter ever exceeds its terminal value.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry hex-to-segment constants,
  - SEG_OFF = 7'h7F,
  - the state encoding (BLANK = 1'b0, SHOW = 1'b1).
- One natural sub-module: hex_to_seg7, a purely combinational 4-bit to 7-bit active-high decoder. It is instantiated once, fed by the mux of data_sh[idx].
- Output inversion and registering stay in seg7_scanner.

Test Plan:
All scenarios use DIGITS=4, DWELL=8, BLANK=2 (frame = 40 cycles).
1. Reset release with data=16'h1234, en=4'hF, dp=0:
   - cycles 0–1 all off;
   - from edge 2, an_n=4'b1110 with seg_n=~7'h66 ('4') for 8 cycles;
   - then 2 off cycles;
   - then an_n=4'b1101 with seg_n=~7'h4F ('3').
2. Full frame check:
   - frame_tick pulses exactly once per 40 cycles;
   - digit order 0,1,2,3,0;
   - an_n never has more than one bit low;
   - an_n is all 1 during every BLANK gap.
3. Snapshot check:
   - change data to 16'hABCD while digit 1 is lit;
   - digits 2 and 3 still show '2' and '1';
   - next frame shows d, C, b, A (seg 5E, 39, 7C, 77).
4. Enable and decimal point:
   - en=4'b0101, dp=4'b0001;
   - digit 0 lit with dp_n=0;
   - digit 1 slot keeps an_n, seg_n and dp_n all high;
   - digit 2 lit with dp_n=1.
5. Mid-scan reset:
   - assert rst during digit 2's dwell;
   - outputs go off in the same cycle without waiting for clk;
   - after release, digit 0 is lit 2 cycles later with a freshly sampled value.
6. All 16 nibbles:
   - sweep data[3:0] over 0..F across successive frames;
   - seg_n matches the inverted decode map for every value.
